cic_interpolator: RTL
=====================

# cic_interpolator

Cascaded integrator-comb interpolator: the transmit-side counterpart of the CIC decimation chain. Accepts narrow signed samples at a low rate on `i_ready` strobes, runs them through N comb stages, zero-stuffs by factor M, and integrates through N stages to produce a full-rate signed output stream. It sits between the sample source and a DAC/modulator path clocked on the same `i_clk`.

## Interface
- `IW`, 2, input sample width (signed)
- `OW`, 16, output and internal datapath width (signed); all comb and integrator registers are `OW` bits
- `M`, 5, interpolation factor (≥2)
- `N`, 3, number of comb and integrator stages (1–6)
- `D`, 1, comb differential delay (1 or 2)

Ports:
- `i_clk`  input  1  clock; all logic is on the rising edge
- `i_reset`  input  1  reset, asynchronous, active-low
- `i_data`  input  IW  signed input sample
- `i_ready`  input  1  one-cycle strobe: `i_data` is valid
- `o_data`  output  OW  signed output sample
- `o_ready`  output  1  one-cycle strobe: `o_data` updated
- `o_busy`  output  1  high when an `i_ready` this cycle would be dropped

## Operation
- Input sign-extended to `OW`.
- Comb section, updated only on accepted `i_ready`: `c_k = c_{k-1} − c_{k-1}` delayed `D` accepted samples, chained combinationally over N stages; only the `N×D` delay registers are stored.
- Upsampler: on acceptance, comb output loads hold register `x`; phase counter `p` loads 1.
- Tick cycle: any cycle with `p≠0`. Stuffer value = `x` when `p==1`, else 0. `p` increments per tick; after `p==M` it returns to 0 unless a new sample is accepted that same cycle.
- Integrators update on ticks only: `int1 <= int1 + stuff`, `int_k <= int_k + int_{k-1}` (old register values), k=2..N. `o_data = int_N`.
- Arithmetic is two's-complement modulo 2^OW; wrap is intended. DC gain is `(M·D)^N / M`. `OW` ≥ `IW + ceil(log2((M·D)^N/M))` is required for valid output; not checked in RTL.
- `o_busy` = `p≠0 && p≠M`. `i_ready` while `o_busy` → sample dropped, no state change.
- `i_ready` when `p==M` → accepted; next cycle is tick `p=1` with new `x`. Gapless streaming therefore uses `i_ready` exactly every M cycles.
- Reset (any time, including mid-burst) clears all comb delays, `x`, `p`, integrators, `o_data`=0, `o_ready`=0, `o_busy`=0. First edge after release behaves as idle.

## Timing
- `i_ready` in cycle 0 → ticks in cycles 1..M → `o_ready` high cycles 2..M+1, one per tick. `o_ready` is registered.
- Impulse reaches `o_data` after N ticks (pipelined integrators).
- With `i_ready` every M cycles, `o_ready` is continuously high from cycle 2.
- Idle: `o_ready`=0 and `o_data` holds its last value.

## Configuration
- `CIC_INTERP_OVERRUN_EN` defined: adds output `o_overrun` (1 bit). It sets sticky on any dropped `i_ready` and clears only on reset.
- Not defined: port absent; dropped samples are silent.

## Structure
- Shared package `cic_pkg`: function `cic_gain_bits(M,N,D)` and the `OW` lower-bound check constant. This package is shared with the decimation chain.
- One natural sub-module: `upsampler`. It contains the phase counter, hold register, `o_busy`, and tick generation.
- Comb and integrator stages are generate loops in the top module.

## Test plan
- Reset: assert `i_reset`=0 mid-burst → all outputs 0 immediately; after release, no `o_ready` until the next `i_ready`.
- Impulse: `i_data`=1 once, then 0 every 5 cycles (defaults) → first five `o_data` on `o_ready`: 0,0,1,3,6.
- DC gain: `i_data`=1 every 5 cycles → `o_data` settles to 25. `i_data`=−2 → settles to −50.
- Streaming: `i_ready` exactly every M cycles for 20 samples → `o_ready` continuously high with no gaps; `o_busy` never blocks.
- Overrun: `i_ready` at cycles 0 and 2 → second sample dropped (`o_busy`=1 at cycle 2), output matches a single-sample stimulus. With `CIC_INTERP_OVERRUN_EN`, `o_overrun`=1 from cycle 3 until reset.
- Boundary accept: `i_ready` at cycle 0 and cycle M → second sample accepted, tick `p=1` occurs at cycle M+1.

Source files
------------

// File: rtl/cic_pkg.sv
// cic_pkg: arithmetic helpers shared by the CIC interpolation and decimation
// chains (gain growth and the minimum datapath width that avoids overflow).
package cic_pkg;

  // Bits of growth for the DC gain (M*D)^N / M, rounded up.
  function automatic int cic_gain_bits(input int m, input int n, input int d);
    longint gain;
    gain = 1;
    for (int k = 0; k < n; k++) begin
      gain = gain * longint'(m * d);
    end
    gain = gain / longint'(m);
    return $clog2(gain);
  endfunction

  // Lower bound on OW for a full-scale IW-bit input to come out unwrapped.
  function automatic int cic_min_ow(input int iw, input int m, input int n, input int d);
    return iw + cic_gain_bits(m, n, d);
  endfunction

endpackage

// File: rtl/cic_interpolator_upsampler.sv
// cic_interpolator_upsampler: zero-stuffing stage of the CIC interpolator.
// Holds the latest comb output, runs the M-phase counter that produces one
// tick per output sample, and flags when a new input sample would be dropped.
module cic_interpolator_upsampler
  import cic_pkg::*;
#(
  parameter int OW = 16,
  parameter int M  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          strobe,
  input  logic [OW-1:0] sample,
  output logic          accept,
  output logic          tick,
  output logic [OW-1:0] stuff,
  output logic          busy
);

  localparam int PW = $clog2(M + 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_LAST = PW'(M);

  logic [PW-1:0] phase;
  logic [OW-1:0] hold;

  // A sample may enter when idle or on the last phase of the current burst,
  // which lets back-to-back samples spaced exactly M cycles stream gaplessly.
  assign busy   = (phase != '0) && (phase != P_LAST);
  assign accept = strobe && !busy;
  assign tick   = (phase != '0);
  assign stuff  = (phase == P_ONE) ? hold : '0;

  // Phase counter and hold register: load on accept, count 1..M, then idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      hold  <= '0;
    end else if (accept) begin
      // NOTE: sequential state always uses <= so every register samples the
      // pre-edge values, independent of statement order.
      phase <= P_ONE;
      hold  <= sample;
    end else if (phase == P_LAST) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + P_ONE;
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator by factor M with comb delay D.
// Low-rate combs run on accepted samples, the upsampler zero-stuffs, and
// N pipelined integrators run at full rate on ticks.
// Optional build macro CIC_INTERP_OVERRUN_EN adds a sticky o_overrun output
// that records any input sample dropped while the upsampler was busy.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int IW = 2,
  parameter int OW = 16,
  parameter int M  = 5,
  parameter int N  = 3,
  parameter int D  = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [IW-1:0] i_data,
  input  logic          i_ready,
  output logic [OW-1:0] o_data,
  output logic          o_ready,
`ifdef CIC_INTERP_OVERRUN_EN
  output logic          o_overrun,
`endif
  output logic          o_busy
);

  logic [OW-1:0] sext;
  logic          accept;
  logic          tick;
  logic [OW-1:0] stuff;
  logic [OW-1:0] comb_out;

  assign sext = {{(OW - IW){i_data[IW-1]}}, i_data};

  // Comb chain: each stage subtracts its input delayed by D accepted samples.
  for (genvar k = 0; k < N; k++) begin : g_comb
    logic [OW-1:0] din;
    logic [OW-1:0] dout;
    logic [OW-1:0] dly [D];

    if (k == 0) begin : g_first
      assign din = sext;
    end else begin : g_next
      assign din = g_comb[k-1].dout;
    end

    assign dout = din - dly[D-1];

    // Delay line advances only when a sample is accepted.
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        // NOTE: this small delay line is reset element by element because the
        // comb history must be clean after reset; large storage arrays would
        // normally be left unreset.
        for (int j = 0; j < D; j++) begin
          dly[j] <= '0;
        end
      end else if (accept) begin
        dly[0] <= din;
        for (int j = 1; j < D; j++) begin
          dly[j] <= dly[j-1];
        end
      end
    end
  end

  assign comb_out = g_comb[N-1].dout;

  cic_interpolator_upsampler #(
    .OW (OW),
    .M  (M)
  ) u_upsampler (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .strobe (i_ready),
    .sample (comb_out),
    .accept (accept),
    .tick   (tick),
    .stuff  (stuff),
    .busy   (o_busy)
  );

  // Integrator chain: each stage adds the previous stage's old value on ticks.
  for (genvar k = 0; k < N; k++) begin : g_int
    logic [OW-1:0] din;
    logic [OW-1:0] acc;

    if (k == 0) begin : g_first
      assign din = stuff;
    end else begin : g_next
      assign din = g_int[k-1].acc;
    end

    // Accumulate on ticks; wrap modulo 2^OW is intended.
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        acc <= '0;
      end else if (tick) begin
        acc <= acc + din;
      end
    end
  end

  assign o_data = g_int[N-1].acc;

  // Output strobe follows the tick that updated the last integrator.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_ready <= 1'b0;
    end else begin
      o_ready <= tick;
    end
  end

`ifdef CIC_INTERP_OVERRUN_EN
  logic dropped;
  assign dropped = i_ready && o_busy;

  // Sticky record of any sample dropped since reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_overrun <= 1'b0;
    end else if (dropped) begin
      o_overrun <= 1'b1;
    end
  end
`endif

endmodule
